mandel_engine_scheduler: RTL
============================

# mandel_engine_scheduler

Frame-level dispatcher for the multi-engine Mandelbrot datapath. It walks the pixel grid in raster order and computes each pixel's complex constant c incrementally. It hands pixels round-robin to `NUM_ENGINES` depth engines and retires their iteration counts to the pixel sink in strict raster order through a valid/ready stream. It sits between the frame/zoom control registers and the colour-map/pixel-packer stage.

## Interface
- `NUM_ENGINES`, 4: number of depth engines driven (≥2, power of 2).
- `WORD_LENGTH`, 32: signed fixed-point word width of c.
- `FRAC`, 28: fractional bits of c (documentation only; arithmetic is width-agnostic).
- `H_RES`, 640: pixels per line.
- `V_RES`, 480: lines per frame.

Ports:
- `sysclk` in 1: single clock; all logic is rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `frame_start` in 1: one-cycle pulse that begins a frame; ignored while `busy`=1.
- `re_origin`, `im_origin` in WORD_LENGTH: c of pixel (0,0), signed; sampled on an accepted `frame_start`.
- `step` in WORD_LENGTH: per-pixel c increment, signed; sampled on an accepted `frame_start`.
- `max_iter_in` in 10: iteration cap; sampled on an accepted `frame_start`.
- `eng_start` out NUM_ENGINES: one-cycle start pulse per engine.
- `eng_re_c`, `eng_im_c` out NUM_ENGINES*WORD_LENGTH: per-engine c; held stable from launch until retire.
- `eng_max_iter` out 10: frame-latched cap, broadcast to all engines.
- `eng_done` in NUM_ENGINES: engine done levels.
- `eng_depth` in NUM_ENGINES*10: engine `final_depth` values.
- `pix_valid` out 1, `pix_ready` in 1: output handshake.
- `pix_depth` out 10, `pix_x` out 10, `pix_y` out 9: retired pixel.
- `pix_eol` out 1: marks the last pixel of a line.
- `pix_last` out 1: marks the last pixel of the frame.
- `busy` out 1: frame in progress.

## Operation
- Each slot i owns engine i. Slot FSM: FREE → LAUNCH → SETTLE → BUSY → HOLD → FREE.
  - LAUNCH: `eng_start[i]`=1 for exactly one cycle; c, x and y are latched into slot registers.
  - SETTLE: one cycle in which `eng_done[i]` is ignored. The engine's done level from the previous pixel is still high here.
  - BUSY: capture `eng_depth[i]` on the first cycle `eng_done[i]`=1, then go to HOLD.
  - HOLD: wait until the slot is retired, then return to FREE.
- Dispatch pointer `dp`: in any cycle where `busy`=1, pixels remain, and slot[dp] is FREE, launch slot[dp] and increment `dp` mod NUM_ENGINES. At most one launch per cycle.
- Retire pointer `rp`: `pix_valid` = (slot[rp] is HOLD). On `pix_valid && pix_ready`, slot[rp] goes to FREE and `rp` increments. Because dispatch and retire use the same rotation, output order is raster order.
- c generation, at full WORD_LENGTH with two's-complement wrap:
  - `re_cur` += `step` per pixel; it reloads to `re_origin` at end of line.
  - `im_cur` starts at `im_origin`; `im_cur` −= `step` per line (y increases downward).
  - No multipliers.
- Counters: x wraps at H_RES−1 → 0 and y increments; dispatch ends after (H_RES−1, V_RES−1).
- `pix_eol` = (`pix_x`==H_RES−1); `pix_last` = `pix_eol` && (`pix_y`==V_RES−1).
- `busy` rises on an accepted `frame_start` and falls the cycle after `pix_last` is accepted.
- `frame_start` while `busy`=1 is dropped with no effect.
- `reset_n` low at any time:
  - All slots FREE, `dp`=`rp`=0, x=y=0.
  - All outputs 0: `eng_start`, `eng_re_c`, `eng_im_c`, `eng_max_iter`, `pix_*`, `busy`.
  - In-flight results are discarded. Engines are reset separately by the same reset.

## Timing
- Accepted `frame_start` in cycle T → `eng_start[0]` in T+1, `eng_start[1]` in T+2, and so on (one launch per cycle while slots are free).
- Minimum launch-to-capture: 3 cycles (LAUNCH, SETTLE, then BUSY sees done). Capture → `pix_valid` in the next cycle.
- `pix_*` are registered and held stable while `pix_valid && !pix_ready`.
- A slot freed by retire in cycle R can be relaunched in R+1, not in R.
- Throughput is bounded by min(NUM_ENGINES / engine latency, 1 pixel/cycle).
- Backpressure: with `pix_ready`=0, at most NUM_ENGINES pixels are in flight, after which dispatch stalls.

## Configuration
- `SCHED_PERF_EN` defined adds two outputs, both cleared on accepted `frame_start` and on reset:
  - `perf_cycles` [31:0]: counts cycles with `busy`=1.
  - `perf_iter_sum` [31:0]: accumulates every retired `pix_depth`.
  - Both saturate at all-ones.
- `SCHED_PERF_EN` undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- H_RES=4, V_RES=2, NUM_ENGINES=2, stub engines with fixed 5-cycle latency returning depth=x+y, `pix_ready`=1 → 8 pixels out in order (0,0)…(3,1), depths 0,1,2,3,1,2,3,4; `pix_eol` on x=3; `pix_last` only on (3,1); `busy` falls the next cycle.
- `re_origin`=−2.0, `im_origin`=+1.0, `step`=0.25 (FRAC=28) → engine for pixel (3,1) receives re_c=−1.25 (0xEC000000) and im_c=+0.75 (0x0C000000).
- Stub engine 1 finishes before engine 0 (latencies 20 vs 4) → `pix_valid` stays low until engine 0's result arrives, then pixel 0 is emitted before pixel 1.
- `pix_ready` held 0 for 50 cycles → exactly NUM_ENGINES `eng_start` pulses, no further launches, and `pix_*` stable; releasing `pix_ready` resumes without loss or duplication.
- Engine leaves `eng_done` high from the previous pixel → the result is not captured during LAUNCH or SETTLE; the new depth is captured only after done re-asserts.
- `reset_n` pulsed low mid-frame → all outputs 0 asynchronously; a new `frame_start` restarts at (0,0); a second `frame_start` while `busy`=1 is ignored.

Source files
------------

// File: rtl/mandel_engine_scheduler.sv
// mandel_engine_scheduler
//   Frame dispatcher for the multi-engine Mandelbrot datapath. Walks the pixel
//   grid in raster order and builds each pixel's c by running addition. Pixels
//   go to NUM_ENGINES depth engines in rotation. Iteration counts are retired
//   in raster order on a valid/ready stream.
//
//   Ports:
//     sysclk, reset_n                  clock, async active-low reset
//     frame_start                      frame request (dropped while busy)
//     re_origin, im_origin, step       c of pixel (0,0) and per-pixel step
//     max_iter_in                      iteration cap, latched per frame
//     eng_start/eng_re_c/eng_im_c      per-engine launch pulse and constant
//     eng_max_iter                     cap broadcast to all engines
//     eng_done/eng_depth               per-engine done level and result
//     pix_valid/pix_ready              retire handshake
//     pix_depth/pix_x/pix_y            retired pixel
//     pix_eol/pix_last                 end-of-line / end-of-frame markers
//     busy                             frame in progress
//   Optional build macro SCHED_PERF_EN adds perf_cycles and perf_iter_sum.

// One dispatch slot. It owns one engine and tracks one pixel from launch to retire.
module mandel_sched_slot #(
    parameter int WORD_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   launch,
    input  logic                   retire,
    input  logic                   done,
    input  logic [9:0]             depth_in,
    input  logic [WORD_LENGTH-1:0] re_in,
    input  logic [WORD_LENGTH-1:0] im_in,
    input  logic [9:0]             x_in,
    input  logic [8:0]             y_in,
    output logic                   start,
    output logic                   free,
    output logic                   hold,
    output logic [WORD_LENGTH-1:0] re_c,
    output logic [WORD_LENGTH-1:0] im_c,
    output logic [9:0]             x,
    output logic [8:0]             y,
    output logic [9:0]             depth
);
    typedef enum logic [2:0] {S_FREE, S_LAUNCH, S_SETTLE, S_BUSY, S_HOLD} slot_state_t;
    slot_state_t state, state_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FREE;
        else        state <= state_nx;
    end

    // SETTLE masks the done level left over from the engine's previous pixel.
    always_comb begin
        state_nx = state;
        case (state)
            S_FREE:   if (launch) state_nx = S_LAUNCH;
            S_LAUNCH: state_nx = S_SETTLE;
            S_SETTLE: state_nx = S_BUSY;
            S_BUSY:   if (done) state_nx = S_HOLD;
            S_HOLD:   if (retire) state_nx = S_FREE;
            default:  state_nx = S_FREE;
        endcase
    end

    assign start = (state == S_LAUNCH);
    assign free  = (state == S_FREE);
    assign hold  = (state == S_HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            re_c  <= '0;
            im_c  <= '0;
            x     <= '0;
            y     <= '0;
            depth <= '0;
        end else begin
            if (launch && state == S_FREE) begin
                re_c <= re_in;
                im_c <= im_in;
                x    <= x_in;
                y    <= y_in;
            end
            if (state == S_BUSY && done) depth <= depth_in;
        end
    end
endmodule

module mandel_engine_scheduler #(
    parameter int NUM_ENGINES = 4,
    parameter int WORD_LENGTH = 32,
    parameter int FRAC        = 28,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480
) (
    input  logic                               sysclk,
    input  logic                               reset_n,
    input  logic                               frame_start,
    input  logic [WORD_LENGTH-1:0]             re_origin,
    input  logic [WORD_LENGTH-1:0]             im_origin,
    input  logic [WORD_LENGTH-1:0]             step,
    input  logic [9:0]                         max_iter_in,
    output logic [NUM_ENGINES-1:0]             eng_start,
    output logic [NUM_ENGINES*WORD_LENGTH-1:0] eng_re_c,
    output logic [NUM_ENGINES*WORD_LENGTH-1:0] eng_im_c,
    output logic [9:0]                         eng_max_iter,
    input  logic [NUM_ENGINES-1:0]             eng_done,
    input  logic [NUM_ENGINES*10-1:0]          eng_depth,
    output logic                               pix_valid,
    input  logic                               pix_ready,
    output logic [9:0]                         pix_depth,
    output logic [9:0]                         pix_x,
    output logic [8:0]                         pix_y,
    output logic                               pix_eol,
    output logic                               pix_last,
`ifdef SCHED_PERF_EN
    output logic [31:0]                        perf_cycles,
    output logic [31:0]                        perf_iter_sum,
`endif
    output logic                               busy
);
    localparam int DPW = $clog2(NUM_ENGINES);

    // c is treated as a plain two's-complement word; FRAC only needs to fit.
    if (FRAC >= WORD_LENGTH || NUM_ENGINES < 2 || (NUM_ENGINES & (NUM_ENGINES - 1)) != 0) begin : g_param_chk
        $error("mandel_engine_scheduler: bad FRAC or NUM_ENGINES");
    end

    logic [DPW-1:0]         dp, rp, dp_eff;
    logic [NUM_ENGINES-1:0] slot_free, slot_hold, launch_vec, retire_vec;
    logic [9:0]             slot_x     [NUM_ENGINES];
    logic [8:0]             slot_y     [NUM_ENGINES];
    logic [9:0]             slot_depth [NUM_ENGINES];

    logic [WORD_LENGTH-1:0] re_cur, im_cur, re_org, stp;
    logic [9:0]             x_cnt;
    logic [8:0]             y_cnt;
    logic                   remain;

    logic                   accept, launch, pix_fire;
    logic [WORD_LENGTH-1:0] b_re, b_im, b_org, b_stp, n_re, n_im;
    logic [9:0]             b_x, n_x;
    logic [8:0]             b_y, n_y;
    logic                   n_remain;

    assign accept   = frame_start && !busy;
    assign pix_fire = pix_valid && pix_ready;

    // On the accepting cycle the frame inputs stand in for the not-yet-loaded
    // registers, so pixel (0,0) launches in that same cycle.
    always_comb begin
        b_x    = accept ? 10'd0     : x_cnt;
        b_y    = accept ? 9'd0      : y_cnt;
        b_re   = accept ? re_origin : re_cur;
        b_im   = accept ? im_origin : im_cur;
        b_org  = accept ? re_origin : re_org;
        b_stp  = accept ? step      : stp;
        dp_eff = accept ? '0        : dp;
        launch = (accept || (busy && remain)) && slot_free[dp_eff];
        if (b_x == 10'(H_RES - 1)) begin
            n_x      = 10'd0;
            n_y      = b_y + 9'd1;
            n_re     = b_org;
            n_im     = b_im - b_stp;
            n_remain = (b_y != 9'(V_RES - 1));
        end else begin
            n_x      = b_x + 10'd1;
            n_y      = b_y;
            n_re     = b_re + b_stp;
            n_im     = b_im;
            n_remain = 1'b1;
        end
    end

    assign launch_vec = NUM_ENGINES'(launch) << dp_eff;
    assign retire_vec = NUM_ENGINES'(pix_fire) << rp;

    for (genvar i = 0; i < NUM_ENGINES; i++) begin : g_slot
        mandel_sched_slot #(.WORD_LENGTH(WORD_LENGTH)) u_slot (
            .clk      (sysclk),
            .rst_n    (reset_n),
            .launch   (launch_vec[i]),
            .retire   (retire_vec[i]),
            .done     (eng_done[i]),
            .depth_in (eng_depth[i*10 +: 10]),
            .re_in    (b_re),
            .im_in    (b_im),
            .x_in     (b_x),
            .y_in     (b_y),
            .start    (eng_start[i]),
            .free     (slot_free[i]),
            .hold     (slot_hold[i]),
            .re_c     (eng_re_c[i*WORD_LENGTH +: WORD_LENGTH]),
            .im_c     (eng_im_c[i*WORD_LENGTH +: WORD_LENGTH]),
            .x        (slot_x[i]),
            .y        (slot_y[i]),
            .depth    (slot_depth[i])
        );
    end

    // Retire follows the same rotation as dispatch, which restores raster order.
    assign pix_valid = slot_hold[rp];
    assign pix_depth = slot_depth[rp];
    assign pix_x     = slot_x[rp];
    assign pix_y     = slot_y[rp];
    assign pix_eol   = (pix_x == 10'(H_RES - 1));
    assign pix_last  = pix_eol && (pix_y == 9'(V_RES - 1));

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            busy         <= 1'b0;
            eng_max_iter <= '0;
            re_org       <= '0;
            stp          <= '0;
            re_cur       <= '0;
            im_cur       <= '0;
            x_cnt        <= '0;
            y_cnt        <= '0;
            remain       <= 1'b0;
            dp           <= '0;
            rp           <= '0;
        end else begin
            if (accept) begin
                busy         <= 1'b1;
                eng_max_iter <= max_iter_in;
                re_org       <= re_origin;
                stp          <= step;
            end else if (pix_fire && pix_last) begin
                busy <= 1'b0;
            end
            if (launch) begin
                x_cnt  <= n_x;
                y_cnt  <= n_y;
                re_cur <= n_re;
                im_cur <= n_im;
                remain <= n_remain;
            end
            dp <= dp_eff + DPW'(launch);
            if (accept)        rp <= '0;
            else if (pix_fire) rp <= rp + DPW'(1);
        end
    end

`ifdef SCHED_PERF_EN
    logic [32:0] iter_acc;
    assign iter_acc = {1'b0, perf_iter_sum} + 33'(pix_depth);

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            perf_cycles   <= '0;
            perf_iter_sum <= '0;
        end else if (accept) begin
            perf_cycles   <= '0;
            perf_iter_sum <= '0;
        end else begin
            if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
            if (pix_fire) perf_iter_sum <= iter_acc[32] ? '1 : iter_acc[31:0];
        end
    end
`endif
endmodule
